// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: issues word requests to imem, buffers in-order responses, presents {instruction, pc} to decode.
// Latency: request accepted in cycle N, response earliest N+1, instr_valid earliest N+2; sustains 1 instr/cycle.
// Backpressure: requests are credit-limited by outstanding count plus FIFO occupancy, so a stalled decode never overflows the buffer.

// Small generic synchronous FIFO with flush; head is read straight from registered storage.
module fetch_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_rdy,
    output logic                         head_vld,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_rdy) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_vld) - CW'(pop_rdy);
        end
    end

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
endmodule

module instr_fetch_unit #(
    parameter logic [31:0]  RESET_PC        = 32'h0000_0000,
    parameter int unsigned  FIFO_DEPTH      = 4,
    parameter int unsigned  MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    logic [31:0]  fetch_pc;
    logic [31:0]  rsp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic         req_fire;
    logic         rsp_fire;
    logic         push;
    logic         pop;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // Handshake decode; redirect suppresses request, push and pop in its cycle.
    always_comb begin
        imem_req_valid = 1'b0;
        if (!rst && !redirect_valid
            && (32'(outstanding) < MAX_OUTSTANDING)
            && ((32'(fifo_count) + 32'(outstanding)) < FIFO_DEPTH)) begin
            imem_req_valid = 1'b1;
        end
        req_fire         = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_fire         = imem_rsp_valid && (outstanding != '0);
        push             = rsp_fire && (discard == '0) && !redirect_valid;
        pop              = instr_valid && instr_ready && !redirect_valid;
        push_entry.instr = imem_rsp_data;
        push_entry.pc    = rsp_pc;
    end

    assign imem_addr = fetch_pc;

    // Fetch/response PCs, in-flight accounting and redirect discard bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding - OW'(rsp_fire) + OW'(req_fire);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h3;
                rsp_pc   <= redirect_pc & ~32'h3;
                // Everything still in flight after this cycle belongs to the old path.
                discard  <= outstanding - OW'(rsp_fire);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_fire) begin
                    if (discard != '0) begin
                        discard <= discard - OW'(1);
                    end else begin
                        rsp_pc <= rsp_pc + 32'd4;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_rdy  (pop),
        .head_vld (instr_valid),
        .head_dat (head_entry),
        .count    (fifo_count)
    );

    assign instruction = head_entry.instr;
    assign instr_pc    = head_entry.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam logic [31:0] K = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instr_fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;

    req_t        pending[$];
    exp_t        sb[$];
    logic [31:0] acc_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          ready_mode = 0;
    int          acc_count = 0;
    int          pop_count = 0;
    int          first_acc_cyc = -1;
    int          first_vld_cyc = -1;
    logic [31:0] exp_fetch = 32'h0;
    logic        want_first = 1'b0;
    logic [31:0] first_pc = 32'hDEAD_BEEF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model: in-order responses mem_lat cycles after accept; expected decode output queued on accept.
    initial begin
        bit rsp_now;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                rsp_now = 1'b0;
                if (pending.size() > 0 && pending[0].due <= cyc) begin
                    rsp_now       = 1'b1;
                    imem_rsp_data = pending[0].addr ^ K;
                    void'(pending.pop_front());
                end
                imem_rsp_valid = rsp_now;
                if (imem_req_valid && imem_req_ready) begin
                    check("outstanding_limit", 32'((pending.size() + int'(rsp_now)) < 2), 32'd1);
                    check("imem_addr", imem_addr, exp_fetch);
                    sb.push_back('{exp_fetch ^ K, exp_fetch});
                    pending.push_back('{imem_addr, cyc + mem_lat});
                    acc_log.push_back(imem_addr);
                    acc_count++;
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every decode handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (!rst && !redirect_valid && instr_valid && instr_ready) begin
                pop_count++;
                if (want_first) begin
                    first_pc   = instr_pc;
                    want_first = 1'b0;
                end
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_instr: got pc %h, expected no output", instr_pc);
                end else begin
                    e = sb.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instruction", instruction, e.instr);
                end
            end
        end
    end

    // imem_req_ready pattern: 0 = always ready, 1 = toggle, 2 = stalled.
    initial begin
        imem_req_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       imem_req_ready = 1'b1;
                1:       imem_req_ready = !imem_req_ready;
                default: imem_req_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 32'd0);
        check("rst_instr_valid", instr_valid, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        @(posedge clk);
        #1;
        exp_fetch     = 32'h0;
        first_acc_cyc = -1;
        first_vld_cyc = -1;
        acc_count     = 0;
        acc_log.delete();
        rst = 1'b0;
    endtask

    task automatic drain();
        ready_mode = 2;
        cycles(12);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_instr_valid", instr_valid, 32'd0);
    endtask

    initial begin
        int p0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;

        // Streaming with 1-cycle memory: latency 2, then 1 instr/cycle.
        mem_lat = 1; ready_mode = 0; instr_ready = 1'b1;
        apply_reset();
        cycles(10);
        p0 = pop_count;
        cycles(10);
        check("throughput", 32'(pop_count - p0), 32'd10);
        check("first_latency", 32'(first_vld_cyc - first_acc_cyc), 32'd2);
        drain();

        // Decode stalled: exactly 4 buffered, requests stop, resume at 16.
        ready_mode = 0; instr_ready = 1'b0;
        apply_reset();
        cycles(12);
        check("held_accepts", 32'(acc_count), 32'd4);
        check("held_req_valid", imem_req_valid, 32'd0);
        check("held_instr_valid", instr_valid, 32'd1);
        check("held_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        cycles(10);
        if (acc_log.size() > 4) check("resume_addr", acc_log[4], 32'h10);
        else check("resume_accepts", 32'(acc_log.size()), 32'd5);
        drain();

        // Toggling request ready with 3-cycle memory.
        mem_lat = 3; ready_mode = 1; instr_ready = 1'b1;
        apply_reset();
        cycles(40);
        check("toggle_progress", 32'(acc_count >= 10), 32'd1);
        drain();

        // Redirect with two responses in flight.
        mem_lat = 3; ready_mode = 0; instr_ready = 1'b0;
        apply_reset();
        cycles(2);
        check("inflight_before_redirect", 32'(pending.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        exp_fetch      = 32'h0000_0100;
        sb.delete();
        first_pc   = 32'hDEAD_BEEF;
        want_first = 1'b1;
        @(negedge clk);
        check("redirect_req_valid", imem_req_valid, 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        cycles(15);
        check("first_pc_after_redirect", first_pc, 32'h0000_0100);
        drain();

        // Address wrap from 0xFFFF_FFF8.
        mem_lat = 1; ready_mode = 0; instr_ready = 1'b1;
        acc_log.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        exp_fetch      = 32'hFFFF_FFF8;
        sb.delete();
        cycles(1);
        redirect_valid = 1'b0;
        cycles(10);
        if (acc_log.size() >= 3) begin
            check("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", acc_log[2], 32'h0000_0000);
        end else begin
            check("wrap_accepts", 32'(acc_log.size()), 32'd3);
        end
        drain();

        // Reset with a full FIFO, then restart from RESET_PC.
        ready_mode = 0; instr_ready = 1'b0;
        apply_reset();
        cycles(12);
        check("full_before_rst", instr_valid, 32'd1);
        rst = 1'b1;
        sb.delete();
        cycles(1);
        check("midrst_instr_valid", instr_valid, 32'd0);
        check("midrst_req_valid", imem_req_valid, 32'd0);
        check("midrst_instruction", instruction, 32'd0);
        exp_fetch     = 32'h0;
        first_acc_cyc = -1;
        first_vld_cyc = -1;
        acc_log.delete();
        first_pc      = 32'hDEAD_BEEF;
        want_first    = 1'b1;
        rst           = 1'b0;
        instr_ready   = 1'b1;
        cycles(10);
        check("restart_first_pc", first_pc, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
